// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} txbuf_state_e;

   localparam int UART_DWIDTH      = 8;
   localparam int UART_TXBUF_DEPTH = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock byte FIFO: storage, wrapping read/write pointers, independent occupancy count.
module uart_sync_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_TXBUF_DEPTH,
   parameter int DWIDTH = UART_DWIDTH,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [DWIDTH-1:0] wr_data,
   input  logic              rd_en,
   output logic [DWIDTH-1:0] rd_data,
   output logic [CW-1:0]     count,
   output logic              full,
   output logic              empty
);

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              wr_ok, rd_ok;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // A write into a full FIFO is only legal when the head leaves in the same cycle.
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO plus drain FSM feeding uart_tx one byte per idle period.
// Optional sticky overflow flag enabled by defining UART_TX_BUF_OVF_EN.
module uart_tx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH  = UART_TXBUF_DEPTH,
   parameter int DWIDTH = UART_DWIDTH
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [DWIDTH-1:0]          push_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       tx_start,
   output logic [DWIDTH-1:0]          tx_data,
   input  logic                       tx_busy,
   output logic                       ovf,
   input  logic                       ovf_clr
);

   txbuf_state_e      state_q, state_d;
   logic              tx_start_q, tx_start_d;
   logic [DWIDTH-1:0] tx_data_q, tx_data_d;
   logic [DWIDTH-1:0] head;
   logic              pop;
   logic              push_ok;

   assign pop     = (state_q == IDLE) && !empty && !tx_busy;
   assign push_ok = push && (!full || pop);

   uart_sync_fifo #(
      .DEPTH  (DEPTH),
      .DWIDTH (DWIDTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push_ok),
      .wr_data (push_data),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   // WAIT_BUSY covers the cycle before uart_tx reflects the start in tx_busy.
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               tx_data_d  = head;
               tx_start_d = 1'b1;
               state_d    = LAUNCH;
            end
         end
         LAUNCH:    state_d = WAIT_BUSY;
         WAIT_BUSY: if (tx_busy)  state_d = WAIT_DONE;
         WAIT_DONE: if (!tx_busy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

`ifdef UART_TX_BUF_OVF_EN
   logic ovf_q, ovf_d;

   always_comb begin
      ovf_d = ovf_q;
      if (push && !push_ok) ovf_d = 1'b1;
      if (ovf_clr)          ovf_d = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ovf_q <= 1'b0;
      else       ovf_q <= ovf_d;
   end

   assign ovf = ovf_q;
`else
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr;
   assign ovf            = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple uart_tx busy model.
module tb_uart_tx_buffer;

   logic       clk;
   logic       reset;
   logic       push;
   logic [7:0] push_data;
   logic       full;
   logic       empty;
   logic [4:0] count;
   logic       tx_start;
   logic [7:0] tx_data;
   logic       tx_busy;
   logic       ovf;
   logic       ovf_clr;

   logic       hold_busy;
   logic       model_busy;
   int         busy_len;
   int         busy_cnt;
   logic [7:0] got[$];
   int         busy_viol;
   int         cnt_viol;
   int         n_vec;
   int         n_err;
   logic       exp_ovf;

   assign tx_busy = hold_busy | model_busy;

   uart_tx_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .tx_start  (tx_start),
      .tx_data   (tx_data),
      .tx_busy   (tx_busy),
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor plus uart_tx stand-in: busy rises after a start and holds busy_len cycles.
   always @(negedge clk) begin
      if (int'(count) > 16) cnt_viol++;
      if (tx_start) begin
         got.push_back(tx_data);
         if (tx_busy) busy_viol++;
         busy_cnt   = busy_len;
         model_busy = 1'b1;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) model_busy = 1'b0;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      push      = 1'b1;
      push_data = b;
      @(posedge clk);
      #1 push   = 1'b0;
   endtask

   task automatic wait_got(input int n, input int budget, input string tag);
      int i;
      i = 0;
      while (got.size() < n && i < budget) begin
         @(posedge clk);
         i++;
      end
      repeat (12) @(posedge clk);
      #1;
      check_val(tag, got.size(), n);
   endtask

   initial begin
      n_vec = 0; n_err = 0;
      busy_viol = 0; cnt_viol = 0;
      busy_len = 4; busy_cnt = 0;
      model_busy = 1'b0; hold_busy = 1'b0;
      push = 1'b0; push_data = '0; ovf_clr = 1'b0;
`ifdef UART_TX_BUF_OVF_EN
      exp_ovf = 1'b1;
`else
      exp_ovf = 1'b0;
`endif

      // 1: reset state and single-byte latency
      do_reset();
      check_val("rst_empty", empty, 1);
      check_val("rst_full", full, 0);
      check_val("rst_count", count, 0);
      check_val("rst_tx_start", tx_start, 0);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_ovf", ovf, 0);
      got.delete();
      push_byte(8'h41);
      check_val("t1_start_n", tx_start, 0);
      check_val("t1_count_n", count, 1);
      @(posedge clk); #1;
      check_val("t1_start_n1", tx_start, 1);
      check_val("t1_data", tx_data, 8'h41);
      check_val("t1_empty", empty, 1);
      check_val("t1_count", count, 0);
      @(posedge clk); #1;
      check_val("t1_start_n2", tx_start, 0);
      wait_got(1, 50, "t1_pulses");
      check_val("t1_hold_data", tx_data, 8'h41);

      // 2: four back-to-back bytes paced by tx_busy
      do_reset();
      got.delete();
      busy_viol = 0;
      for (int i = 0; i < 4; i++) push_byte(8'h10 + 8'(i));
      wait_got(4, 150, "t2_pulses");
      for (int i = 0; i < 4; i++) check_val($sformatf("t2_byte%0d", i), got[i], 8'h10 + 8'(i));
      check_val("t2_busy_overlap", busy_viol, 0);

      // 3: fill while transmitter busy, overflow flag behaviour
      do_reset();
      got.delete();
      hold_busy = 1'b1;
      for (int i = 0; i < 17; i++) push_byte(8'h20 + 8'(i));
      check_val("t3_full", full, 1);
      check_val("t3_count", count, 16);
      check_val("t3_ovf", ovf, exp_ovf);
      repeat (3) @(posedge clk); #1;
      check_val("t3_ovf_sticky", ovf, exp_ovf);
      ovf_clr = 1'b1;
      push_byte(8'h31);
      ovf_clr = 1'b0;
      check_val("t3_ovf_clr_wins", ovf, 0);
      check_val("t3_count_after_drop", count, 16);
      @(posedge clk); #1;
      check_val("t3_ovf_cleared", ovf, 0);
      check_val("t3_no_start", got.size(), 0);

      // 4: push on the pop cycle of a full FIFO
      hold_busy = 1'b0;
      push_byte(8'hAA);
      check_val("t4_count", count, 16);
      check_val("t4_full", full, 1);
      check_val("t4_start", tx_start, 1);
      check_val("t4_first", tx_data, 8'h20);
      wait_got(17, 400, "t4_pulses");
      for (int i = 0; i < 16; i++) check_val($sformatf("t4_byte%0d", i), got[i], 8'h20 + 8'(i));
      check_val("t4_last", got[16], 8'hAA);
      check_val("t4_empty", empty, 1);
      check_val("t4_count_end", count, 0);

      // 5: twenty bytes with interleaved pushes and drains, pointers wrap
      do_reset();
      got.delete();
      cnt_viol = 0;
      busy_viol = 0;
      for (int i = 0; i < 10; i++) push_byte(8'h50 + 8'(i));
      repeat (8) @(posedge clk); #1;
      for (int i = 10; i < 20; i++) begin
         push_byte(8'h50 + 8'(i));
         @(posedge clk); #1;
      end
      wait_got(20, 400, "t5_pulses");
      for (int i = 0; i < 20; i++) check_val($sformatf("t5_byte%0d", i), got[i], 8'h50 + 8'(i));
      check_val("t5_count_range", cnt_viol, 0);
      check_val("t5_busy_overlap", busy_viol, 0);
      check_val("t5_empty", empty, 1);

      // 6: reset while waiting for the transmitter with bytes queued
      do_reset();
      got.delete();
      busy_len = 30;
      for (int i = 0; i < 6; i++) push_byte(8'h60 + 8'(i));
      wait_got(1, 50, "t6_first");
      check_val("t6_queued", count, 5);
      reset = 1'b1;
      #1;
      check_val("t6_rst_empty", empty, 1);
      check_val("t6_rst_count", count, 0);
      check_val("t6_rst_start", tx_start, 0);
      check_val("t6_rst_data", tx_data, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (40) @(posedge clk); #1;
      check_val("t6_no_start", got.size(), 1);
      busy_len = 4;
      push_byte(8'h77);
      wait_got(2, 60, "t6_new_push");
      check_val("t6_new_byte", got[1], 8'h77);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
